// File: rtl/apb_master.sv
// APB2 requester: one local command at a time becomes an APB SETUP/ACCESS transfer to slave 1 or 2.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT cycles without PREADY.
module apb_master #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                psel1_q;
    logic                psel2_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    // Top two address bits select the slave; 1x has no slave behind it.
    logic [1:0] dec_bits;
    assign dec_bits = cmd_addr[ADDR_W-1:ADDR_W-2];

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_hit;
    assign timeout_hit = (wait_cnt_q == CntW'(TIMEOUT - 1));
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready_q) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        if (dec_bits[1]) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            psel1_q     <= ~dec_bits[0];
                            psel2_q     <= dec_bits[0];
                            cmd_ready_q <= 1'b0;
                            state_q     <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    penable_q  <= 1'b1;
                    state_q    <= StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                StAccess: begin
                    if (PREADY) begin
                        psel1_q     <= 1'b0;
                        psel2_q     <= 1'b0;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= psel2_q ? PRDATA2 : PRDATA1;
                        end
                        state_q     <= StIdle;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        psel1_q     <= 1'b0;
                        psel2_q     <= 1'b0;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
